uart_tx_buffered: RTL

- Buffered 8N1 UART transmitter for the PC-facing link. The PC-to-UART path hands it bytes over a valid/ready handshake.
- Bytes go into a small synchronous FIFO and are serialized LSB-first onto txd_o at a fixed bit period.
- Frames are sent back-to-back while the FIFO holds data. Upstream logic can burst bytes without waiting for each frame to finish.

---
 rtl/uart_tx_buffered_if.sv | 31 +++
 rtl/uart_tx_buffered.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/uart_tx_buffered_if.sv
// Byte handshake into the buffered UART transmitter plus its line and status outputs.
interface uart_tx_buffered_if #(
    parameter int FIFO_DEPTH = 8
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic [7:0]    data_i;
    logic          valid_i;
    logic          ready_o;
    logic          txd_o;
    logic          busy_o;
    logic [CW-1:0] count_o;

    modport master (
        output data_i,
        output valid_i,
        input  ready_o,
        input  txd_o,
        input  busy_o,
        input  count_o
    );

    modport slave (
        input  data_i,
        input  valid_i,
        output ready_o,
        output txd_o,
        output busy_o,
        output count_o
    );
endinterface

// File: rtl/uart_tx_buffered.sv
// Buffered 8N1 UART transmitter: FIFO-fed, LSB-first, 2 cycles from accept to start bit when idle.
// Backpressure: ready drops only while the FIFO holds FIFO_DEPTH bytes; queued frames go out back-to-back.
module uart_tx_buffered #(
    parameter int CLKS_PER_BIT = 104,
    parameter int FIFO_DEPTH   = 8,
    parameter int STOP_BITS    = 1
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    uart_tx_buffered_if.slave bus
);
    localparam int AW        = $clog2(FIFO_DEPTH);
    localparam int CW        = AW + 1;
    localparam int STOP_CLKS = STOP_BITS * CLKS_PER_BIT;
    localparam int TW        = $clog2(STOP_CLKS);

    localparam logic [TW-1:0] BIT_LAST  = TW'(CLKS_PER_BIT - 1);
    localparam logic [TW-1:0] STOP_LAST = TW'(STOP_CLKS - 1);
    localparam logic [CW-1:0] FULL      = CW'(FIFO_DEPTH);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_START = 2'd1;
    localparam logic [1:0] S_DATA  = 2'd2;
    localparam logic [1:0] S_STOP  = 2'd3;

    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          push;
    logic          pop;
    logic          has_data;

    logic [1:0]    state;
    logic [TW-1:0] timer;
    logic [2:0]    bit_idx;
    logic [7:0]    shift;
    logic          line_val;
    logic          txd;
    logic          line_active;

    assign has_data    = (count != '0);
    assign bus.ready_o = (count != FULL);
    assign push        = bus.valid_i && bus.ready_o;

    always_ff @(posedge clk_i) begin
        if (push) begin
            mem[wr_ptr] <= bus.data_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // A byte pushed during the final stop cycle is not visible yet, so that case falls back to IDLE.
    always_comb begin
        pop = 1'b0;
        if (has_data && (state == S_IDLE)) begin
            pop = 1'b1;
        end
        if (has_data && (state == S_STOP) && (timer == STOP_LAST)) begin
            pop = 1'b1;
        end
    end

    always_comb begin
        case (state)
            S_START: line_val = 1'b0;
            S_DATA:  line_val = shift[bit_idx];
            default: line_val = 1'b1;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state       <= S_IDLE;
            timer       <= '0;
            bit_idx     <= '0;
            shift       <= '0;
            txd         <= 1'b1;
            line_active <= 1'b0;
        end else begin
            txd         <= line_val;
            line_active <= (state != S_IDLE);
            case (state)
                S_IDLE: begin
                    if (pop) begin
                        shift <= mem[rd_ptr];
                        timer <= '0;
                        state <= S_START;
                    end
                end
                S_START: begin
                    if (timer == BIT_LAST) begin
                        timer   <= '0;
                        bit_idx <= '0;
                        state   <= S_DATA;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                S_DATA: begin
                    if (timer == BIT_LAST) begin
                        timer <= '0;
                        if (bit_idx == 3'd7) begin
                            state <= S_STOP;
                        end else begin
                            bit_idx <= bit_idx + 1'b1;
                        end
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                S_STOP: begin
                    if (timer == STOP_LAST) begin
                        timer <= '0;
                        if (pop) begin
                            shift <= mem[rd_ptr];
                            state <= S_START;
                        end else begin
                            state <= S_IDLE;
                        end
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // line_active covers the last stop cycle, which leaves the txd register after the FSM is back in IDLE.
    assign bus.txd_o   = txd;
    assign bus.busy_o  = line_active || (state != S_IDLE) || has_data;
    assign bus.count_o = count;
endmodule
